// File: rtl/life_pkg.sv
// life_pkg: shared game/player state encodings for the life sequencer
package life_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;
    typedef enum logic [1:0] {ALIVE, DYING, RESPAWN, OUT} player_state_t;
    localparam int BLINK_BIT = 2;
endpackage

// File: rtl/player_life_fsm.sv
// player_life_fsm: one player's death/respawn/invulnerability timeline and lives counter
module player_life_fsm
    import life_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 90
)(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       dead_edge,
    input  logic       enable,
    input  logic       reload,
    output logic [1:0] lives,
    output logic       freeze,
    output logic       visible,
    output logic       respawn,
    output logic       done_pulse,
    output logic       is_out
);
    player_state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] lives_n;
    logic respawn_n, done_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ALIVE;
            cnt        <= '0;
            lives      <= 2'(START_LIVES);
            respawn    <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lives      <= lives_n;
            respawn    <= respawn_n;
            done_pulse <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lives_n   = lives;
        respawn_n = 1'b0;
        done_n    = 1'b0;
        if (reload) begin
            state_n = ALIVE;
            cnt_n   = '0;
            lives_n = 2'(START_LIVES);
        end else if (enable) begin
            case (state)
                ALIVE: if (dead_edge) begin
                    state_n = DYING;
                    cnt_n   = '0;
                    lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                end
                DYING: if (tick) begin
                    if (cnt == 8'(DEATH_FRAMES - 1)) begin
                        state_n   = (lives != 2'd0) ? RESPAWN : OUT;
                        cnt_n     = '0;
                        respawn_n = (lives != 2'd0);
                        done_n    = 1'b1;
                    end else
                        cnt_n = cnt + 8'd1;
                end
                RESPAWN: if (tick) begin
                    state_n = (cnt == 8'(INVULN_FRAMES - 1)) ? ALIVE : RESPAWN;
                    cnt_n   = (cnt == 8'(INVULN_FRAMES - 1)) ? 8'd0 : cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign freeze  = (state == DYING) || (state == OUT);
    assign visible = (state == RESPAWN) ? ~cnt[BLINK_BIT] : (state != OUT);
    assign is_out  = (state == OUT);
endmodule

// File: rtl/life_sequencer.sv
// life_sequencer: game FSM, edge detection, goomba respawn timer and collision reset merge
module life_sequencer
    import life_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 90,
    parameter int GOMBA_FRAMES  = 120
)(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_Clk,
    input  logic       start,
    input  logic       mario_dead,
    input  logic       luigi_dead,
    input  logic       gomba_dead,
    output logic [1:0] mario_lives,
    output logic [1:0] luigi_lives,
    output logic       mario_freeze,
    output logic       luigi_freeze,
    output logic       mario_visible,
    output logic       luigi_visible,
    output logic       mario_respawn,
    output logic       luigi_respawn,
    output logic       gomba_respawn,
    output logic       coll_reset,
    output logic [1:0] game_state
);
    game_state_t game, game_n;
    logic frame_q, tick, mario_q, luigi_q, gomba_q, mario_edge, luigi_edge, gomba_edge;
    logic start_pls, start_pls_n, gomba_busy, gomba_busy_n, gomba_pls, gomba_pls_n;
    logic [7:0] gomba_cnt, gomba_cnt_n;
    logic mario_rsp, luigi_rsp, mario_done, luigi_done, mario_out, luigi_out;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            {frame_q, tick, mario_q, luigi_q, gomba_q} <= '0;
            {mario_edge, luigi_edge, gomba_edge}      <= '0;
            game       <= IDLE;
            start_pls  <= 1'b0;
            gomba_busy <= 1'b0;
            gomba_pls  <= 1'b0;
            gomba_cnt  <= '0;
        end else begin
            frame_q    <= frame_Clk;
            tick       <= frame_Clk & ~frame_q;
            mario_q    <= mario_dead;
            luigi_q    <= luigi_dead;
            gomba_q    <= gomba_dead;
            mario_edge <= mario_dead & ~mario_q;
            luigi_edge <= luigi_dead & ~luigi_q;
            gomba_edge <= gomba_dead & ~gomba_q;
            game       <= game_n;
            start_pls  <= start_pls_n;
            gomba_busy <= gomba_busy_n;
            gomba_pls  <= gomba_pls_n;
            gomba_cnt  <= gomba_cnt_n;
        end
    end

    always_comb begin
        game_n       = game;
        start_pls_n  = 1'b0;
        gomba_busy_n = gomba_busy;
        gomba_cnt_n  = gomba_cnt;
        gomba_pls_n  = 1'b0;
        case (game)
            IDLE: begin
                gomba_busy_n = 1'b0;
                game_n       = start ? PLAY : IDLE;
                start_pls_n  = start;
            end
            PLAY: begin
                game_n = (mario_out && luigi_out) ? OVER : PLAY;
                // edges arriving while the timer runs are dropped
                if (!gomba_busy && gomba_edge) begin
                    gomba_busy_n = 1'b1;
                    gomba_cnt_n  = '0;
                end else if (gomba_busy && tick) begin
                    gomba_busy_n = (gomba_cnt != 8'(GOMBA_FRAMES - 1));
                    gomba_pls_n  = (gomba_cnt == 8'(GOMBA_FRAMES - 1));
                    gomba_cnt_n  = gomba_cnt + 8'd1;
                end
            end
            OVER: game_n = start ? IDLE : OVER;
            default: game_n = IDLE;
        endcase
    end

    player_life_fsm #(.START_LIVES(START_LIVES), .DEATH_FRAMES(DEATH_FRAMES), .INVULN_FRAMES(INVULN_FRAMES)) u_mario (
        .Clk(Clk), .Reset(Reset), .tick(tick), .dead_edge(mario_edge),
        .enable(game == PLAY), .reload(game == IDLE),
        .lives(mario_lives), .freeze(mario_freeze), .visible(mario_visible),
        .respawn(mario_rsp), .done_pulse(mario_done), .is_out(mario_out)
    );

    player_life_fsm #(.START_LIVES(START_LIVES), .DEATH_FRAMES(DEATH_FRAMES), .INVULN_FRAMES(INVULN_FRAMES)) u_luigi (
        .Clk(Clk), .Reset(Reset), .tick(tick), .dead_edge(luigi_edge),
        .enable(game == PLAY), .reload(game == IDLE),
        .lives(luigi_lives), .freeze(luigi_freeze), .visible(luigi_visible),
        .respawn(luigi_rsp), .done_pulse(luigi_done), .is_out(luigi_out)
    );

    assign mario_respawn = mario_rsp | start_pls;
    assign luigi_respawn = luigi_rsp | start_pls;
    assign gomba_respawn = gomba_pls | start_pls;
    assign coll_reset    = start_pls | mario_done | luigi_done | gomba_pls;
    assign game_state    = game;
endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: directed + randomized checks of life_sequencer against a frame-timeline model
module tb_life_sequencer;
    localparam int SL = 3, DF = 4, IVF = 12, GF = 3;

    logic Clk = 1'b0, Reset = 1'b1, frame_Clk = 1'b0, start = 1'b0;
    logic mario_dead = 1'b0, luigi_dead = 1'b0, gomba_dead = 1'b0;
    logic [1:0] mario_lives, luigi_lives, game_state;
    logic mario_freeze, luigi_freeze, mario_visible, luigi_visible;
    logic mario_respawn, luigi_respawn, gomba_respawn, coll_reset;

    int n_assert = 0, n_fail = 0;
    int m_game, m_spls, m_gpls, m_gleft, m_tick, m_fprev, m_gprev, m_ged;
    int ph [2], left [2], lv [2], rp [2], dn [2], ed [2], pv [2];
    int fcnt = 0, c_mr, c_lr, c_gr, c_cr, vis_tog;
    logic vis_prev = 1'b1;

    always #5 Clk = ~Clk;

    life_sequencer #(.START_LIVES(SL), .DEATH_FRAMES(DF), .INVULN_FRAMES(IVF), .GOMBA_FRAMES(GF)) dut (
        .Clk(Clk), .Reset(Reset), .frame_Clk(frame_Clk), .start(start),
        .mario_dead(mario_dead), .luigi_dead(luigi_dead), .gomba_dead(gomba_dead),
        .mario_lives(mario_lives), .luigi_lives(luigi_lives),
        .mario_freeze(mario_freeze), .luigi_freeze(luigi_freeze),
        .mario_visible(mario_visible), .luigi_visible(luigi_visible),
        .mario_respawn(mario_respawn), .luigi_respawn(luigi_respawn),
        .gomba_respawn(gomba_respawn), .coll_reset(coll_reset), .game_state(game_state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        n_assert++;
        assert (obs === 8'(exp)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Phases: 0 alive, 1 dying, 2 respawn-blink, 3 out; left counts remaining frame ticks.
    task automatic model_step();
        int d [2];
        int g0;
        bit both_out;
        d[0] = mario_dead;
        d[1] = luigi_dead;
        if (Reset) begin
            m_game = 0; m_spls = 0; m_gpls = 0; m_gleft = -1;
            m_tick = 0; m_fprev = 0; m_gprev = 0; m_ged = 0;
            for (int p = 0; p < 2; p++) begin
                ph[p] = 0; left[p] = 0; lv[p] = SL; rp[p] = 0; dn[p] = 0; ed[p] = 0; pv[p] = 0;
            end
            return;
        end
        g0 = m_game;
        both_out = (ph[0] == 3) && (ph[1] == 3);
        m_spls = (g0 == 0 && start) ? 1 : 0;
        m_gpls = 0;
        for (int p = 0; p < 2; p++) begin
            rp[p] = 0;
            dn[p] = 0;
            if (g0 == 0) begin
                ph[p] = 0;
                lv[p] = SL;
            end else if (g0 == 1) begin
                if (ph[p] == 0 && ed[p] != 0) begin
                    ph[p] = 1; left[p] = DF; lv[p] = (lv[p] > 0) ? lv[p] - 1 : 0;
                end else if (ph[p] == 1 && m_tick != 0) begin
                    left[p]--;
                    if (left[p] == 0) begin
                        dn[p] = 1;
                        if (lv[p] > 0) begin ph[p] = 2; left[p] = IVF; rp[p] = 1; end
                        else ph[p] = 3;
                    end
                end else if (ph[p] == 2 && m_tick != 0) begin
                    left[p]--;
                    if (left[p] == 0) ph[p] = 0;
                end
            end
        end
        if (g0 == 0) m_gleft = -1;
        else if (g0 == 1) begin
            if (m_gleft < 0 && m_ged != 0) m_gleft = GF;
            else if (m_gleft > 0 && m_tick != 0) begin
                m_gleft--;
                if (m_gleft == 0) begin m_gpls = 1; m_gleft = -1; end
            end
        end
        if (g0 == 0 && start) m_game = 1;
        else if (g0 == 1 && both_out) m_game = 2;
        else if (g0 == 2 && start) m_game = 0;
        m_tick = (frame_Clk && m_fprev == 0) ? 1 : 0;
        m_fprev = frame_Clk;
        m_ged = (gomba_dead && m_gprev == 0) ? 1 : 0;
        m_gprev = gomba_dead;
        for (int p = 0; p < 2; p++) begin
            ed[p] = (d[p] != 0 && pv[p] == 0) ? 1 : 0;
            pv[p] = d[p];
        end
    endtask

    function automatic int vis(input int p);
        if (ph[p] == 3) return 0;
        if (ph[p] == 2) return (((IVF - left[p]) / 4) % 2 == 0) ? 1 : 0;
        return 1;
    endfunction

    task automatic check_all();
        chk("game_state", game_state, m_game);
        chk("mario_lives", mario_lives, lv[0]);
        chk("luigi_lives", luigi_lives, lv[1]);
        chk("mario_freeze", mario_freeze, (ph[0] == 1 || ph[0] == 3) ? 1 : 0);
        chk("luigi_freeze", luigi_freeze, (ph[1] == 1 || ph[1] == 3) ? 1 : 0);
        chk("mario_visible", mario_visible, vis(0));
        chk("luigi_visible", luigi_visible, vis(1));
        chk("mario_respawn", mario_respawn, rp[0] | m_spls);
        chk("luigi_respawn", luigi_respawn, rp[1] | m_spls);
        chk("gomba_respawn", gomba_respawn, m_gpls | m_spls);
        chk("coll_reset", coll_reset, m_spls | dn[0] | dn[1] | m_gpls);
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_step();
        #1;
        check_all();
        c_mr += int'(mario_respawn);
        c_lr += int'(luigi_respawn);
        c_gr += int'(gomba_respawn);
        c_cr += int'(coll_reset);
        if (mario_visible !== vis_prev) vis_tog++;
        vis_prev = mario_visible;
        if (fcnt == 0) begin
            frame_Clk = 1'b1;
            fcnt = $urandom_range(2, 5);
        end else begin
            frame_Clk = 1'b0;
            fcnt--;
        end
    endtask

    task automatic clr();
        c_mr = 0; c_lr = 0; c_gr = 0; c_cr = 0; vis_tog = 0;
    endtask

    initial begin
        Reset = 1'b1;
        repeat (3) cyc();
        Reset = 1'b0;
        cyc();
        chk("reset_game", game_state, 0);
        chk("reset_lives", mario_lives, SL);
        clr();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("start_play", game_state, 1);
        chk("start_mario_rsp_cnt", 8'(c_mr), 1);
        chk("start_luigi_rsp_cnt", 8'(c_lr), 1);
        chk("start_gomba_rsp_cnt", 8'(c_gr), 1);
        chk("start_coll_cnt", 8'(c_cr), 1);
        chk("start_lives", {mario_lives, luigi_lives}, 4'({2'(SL), 2'(SL)}));
        clr();
        mario_dead = 1'b1;
        for (int i = 0; i < 300 && !mario_respawn; i++) cyc();
        chk("death_respawn_seen", mario_respawn, 1);
        chk("death_lives", mario_lives, 2);
        chk("death_coll_cnt", 8'(c_cr), 1);
        mario_dead = 1'b0;
        cyc();
        cyc();
        mario_dead = 1'b1;
        cyc();
        mario_dead = 1'b0;
        for (int i = 0; i < 400 && ph[0] != 0; i++) cyc();
        cyc();
        chk("blink_lives_kept", mario_lives, 2);
        chk("blink_toggles", 8'(vis_tog), 2);
        chk("blink_end_visible", mario_visible, 1);
        chk("blink_respawn_cnt", 8'(c_mr), 1);
        clr();
        mario_dead = 1'b1;
        luigi_dead = 1'b1;
        cyc();
        chk("simul_not_yet", mario_freeze | luigi_freeze, 0);
        cyc();
        chk("simul_both_freeze", {mario_freeze, luigi_freeze}, 3);
        for (int i = 0; i < 500 && (ph[0] != 0 || ph[1] != 0); i++) cyc();
        chk("simul_mario_lives", mario_lives, 1);
        chk("simul_luigi_lives", luigi_lives, 2);
        chk("simul_coll_cnt", 8'(c_cr), 1);
        chk("simul_rsp_cnt", 8'(c_mr + c_lr), 2);
        mario_dead = 1'b0;
        luigi_dead = 1'b0;
        for (int i = 0; i < 6000 && m_game != 2; i++) begin
            mario_dead = ($urandom_range(0, 7) == 0);
            luigi_dead = ($urandom_range(0, 7) == 0);
            gomba_dead = ($urandom_range(0, 9) == 0);
            cyc();
        end
        mario_dead = 1'b0;
        luigi_dead = 1'b0;
        gomba_dead = 1'b0;
        cyc();
        chk("over_state", game_state, 2);
        chk("over_visible", {mario_visible, luigi_visible}, 0);
        chk("over_lives", {mario_lives, luigi_lives}, 0);
        chk("over_freeze", {mario_freeze, luigi_freeze}, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
        chk("idle_state", game_state, 0);
        chk("idle_lives", {mario_lives, luigi_lives}, 4'({2'(SL), 2'(SL)}));
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        clr();
        gomba_dead = 1'b1;
        for (int i = 0; i < 200 && !gomba_respawn; i++) cyc();
        chk("gomba_respawn_seen", gomba_respawn, 1);
        chk("gomba_coll_with_rsp", coll_reset, 1);
        gomba_dead = 1'b0;
        repeat (30) cyc();
        chk("gomba_single", 8'(c_gr), 1);
        mario_dead = 1'b1;
        for (int i = 0; i < 50 && !mario_freeze; i++) cyc();
        chk("rst_mid_dying_freeze", mario_freeze, 1);
        cyc();
        Reset = 1'b1;
        mario_dead = 1'b0;
        cyc();
        chk("rst_game", game_state, 0);
        chk("rst_lives", {mario_lives, luigi_lives}, 4'({2'(SL), 2'(SL)}));
        chk("rst_freeze", {mario_freeze, luigi_freeze}, 0);
        chk("rst_visible", {mario_visible, luigi_visible}, 3);
        chk("rst_pulses", {mario_respawn, luigi_respawn, gomba_respawn, coll_reset}, 0);
        Reset = 1'b0;
        repeat (5) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
